// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client round-robin arbiter in front of a single block RAM.
// Client 0 is the I-cache and client 1 is the D-cache. Only one request goes
// to the RAM at a time. Each client's response is held until its request
// changes or drops.
module mem_arbiter #(
   parameter int BLOCK_BITS = 128,
   parameter int REQ_W      = BLOCK_BITS + 36,
   parameter int RSP_W      = BLOCK_BITS + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [REQ_W-1:0] Req0,
   input  logic [REQ_W-1:0] Req1,
   output logic [RSP_W-1:0] Rsp0,
   output logic [RSP_W-1:0] Rsp1,
   output logic [REQ_W-1:0] MemReq,
   input  logic [RSP_W-1:0] MemRsp,
   output logic             Grant
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

   state_t                r_state;
   logic                  r_grant;
   logic                  r_last;
   logic                  r_rdy0, r_rdy1;
   logic [BLOCK_BITS-1:0] r_data0, r_data1;
   logic [REQ_W-1:0]      r_cap0, r_cap1;

   logic                  w_match0, w_match1;
   logic                  w_elig0, w_elig1;
   logic                  w_pick;
   logic [REQ_W-1:0]      w_greq;

   // A request that has already completed and is unchanged must not be re-served.
   assign w_match0 = (Req0 == r_cap0);
   assign w_match1 = (Req1 == r_cap1);
   assign w_elig0  = Req0[32] & ~(r_rdy0 & w_match0);
   assign w_elig1  = Req1[32] & ~(r_rdy1 & w_match1);

   // On a tie, pick the client that did not win last time.
   assign w_pick   = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
   assign w_greq   = r_grant ? Req1 : Req0;

   // RAM sees the granted request only while BUSY. Async reset drops it at once.
   assign MemReq   = (r_state == S_BUSY) ? w_greq : '0;

   // Ready is valid only while the client still presents the captured request.
   assign Rsp0     = {r_data0, r_rdy0 & Req0[32] & w_match0};
   assign Rsp1     = {r_data1, r_rdy1 & Req1[32] & w_match1};
   assign Grant    = r_grant;

   // Arbitration FSM and per-client response and capture storage.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
         r_rdy0  <= 1'b0;
         r_rdy1  <= 1'b0;
         r_data0 <= '0;
         r_data1 <= '0;
         r_cap0  <= '0;
         r_cap1  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_elig0 | w_elig1) begin
                  r_grant <= w_pick;
                  if (w_pick) begin
                     r_cap1 <= Req1;
                     r_rdy1 <= 1'b0;
                  end else begin
                     r_cap0 <= Req0;
                     r_rdy0 <= 1'b0;
                  end
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               // A completion takes priority over a valid drop in the same cycle.
               if (MemRsp[0]) begin
                  if (r_grant) begin
                     r_data1 <= MemRsp[RSP_W-1:1];
                     r_rdy1  <= 1'b1;
                  end else begin
                     r_data0 <= MemRsp[RSP_W-1:1];
                     r_rdy0  <= 1'b1;
                  end
                  r_last  <= r_grant;
                  r_state <= S_RELEASE;
               end else if (!w_greq[32]) begin
                  r_state <= S_RELEASE;
               end
            end
            S_RELEASE: r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A behavioural 3-cycle RAM sits behind the DUT.
// Expected response blocks are queued per client and popped whenever that
// client's ready rises.
module tb_mem_arbiter;
   localparam int BLOCK_BITS = 128;
   localparam int REQ_W      = BLOCK_BITS + 36;
   localparam int RSP_W      = BLOCK_BITS + 1;

   logic             CLK, RST;
   logic [REQ_W-1:0] Req0, Req1, MemReq;
   logic [RSP_W-1:0] Rsp0, Rsp1, MemRsp;
   logic             Grant;

   int n_chk = 0, n_err = 0;
   logic [BLOCK_BITS-1:0] q0[$], q1[$];
   logic                  glog[$];
   int                    lat0, lat1, n;

   mem_arbiter #(.BLOCK_BITS(BLOCK_BITS), .REQ_W(REQ_W), .RSP_W(RSP_W)) dut (
      .CLK(CLK), .RST(RST), .Req0(Req0), .Req1(Req1), .Rsp0(Rsp0), .Rsp1(Rsp1),
      .MemReq(MemReq), .MemRsp(MemRsp), .Grant(Grant)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [BLOCK_BITS-1:0] ram_blk(input logic [31:0] a);
      if (a == 32'h40) return {32{4'h1}};
      return {a ^ 32'hC0DE0000, ~a, a, 32'h5A5A0000 | a};
   endfunction

   // RAM model: ready 3 edges after the request appears, and it clears when the request goes away.
   logic [1:0]            ram_cnt;
   logic                  ram_rdy;
   logic [BLOCK_BITS-1:0] ram_dat;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ram_cnt <= 0; ram_rdy <= 0; ram_dat <= '0;
      end else if (!MemReq[32]) begin
         ram_cnt <= 0; ram_rdy <= 0;
      end else if (!ram_rdy) begin
         if (ram_cnt == 2) begin
            ram_rdy <= 1'b1;
            ram_dat <= ram_blk(MemReq[31:0]);
         end else ram_cnt <= ram_cnt + 1'b1;
      end
   end
   assign MemRsp = {ram_dat, ram_rdy};

   task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: on a rising ready, pop the expected block. On a rising MemReq valid, log the grant.
   logic p0 = 0, p1 = 0, pm = 0;
   always begin
      @(posedge CLK); #1;
      if (Rsp0[0] && !p0) begin
         if (q0.size() == 0) chk("rsp0_unexp", Rsp0[0], 0);
         else chk("rsp0_data", Rsp0[RSP_W-1:1], q0.pop_front());
      end
      if (Rsp1[0] && !p1) begin
         if (q1.size() == 0) chk("rsp1_unexp", Rsp1[0], 0);
         else chk("rsp1_data", Rsp1[RSP_W-1:1], q1.pop_front());
      end
      if (MemReq[32] && !pm) glog.push_back(Grant);
      p0 = Rsp0[0]; p1 = Rsp1[0]; pm = MemReq[32];
   end

   task automatic drive_req(input int c, input logic [31:0] a, input logic t, input logic push);
      logic [REQ_W-1:0] r;
      r = {(t ? {4{a}} : {BLOCK_BITS{1'b0}}), 2'b10, t, 1'b1, a};
      @(negedge CLK);
      if (c == 0) Req0 = r; else Req1 = r;
      if (push) begin
         if (c == 0) q0.push_back(ram_blk(a)); else q1.push_back(ram_blk(a));
      end
      #1;
      if (c == 0) chk("rdy0_new", Rsp0[0], 0); else chk("rdy1_new", Rsp1[0], 0);
   endtask

   task automatic wait_rdy(input int c, output int lat);
      logic r;
      r = 0; lat = 0;
      while (lat < 60 && !r) begin
         @(posedge CLK); #1;
         lat++;
         r = (c == 0) ? Rsp0[0] : Rsp1[0];
      end
      chk(c == 0 ? "wait_rdy0" : "wait_rdy1", r, 1);
   endtask

   task automatic wait_busy(input logic g);
      int k;
      k = 0;
      do begin
         @(posedge CLK); #1; k++;
      end while (k < 30 && !(MemReq[32] && Grant == g));
      chk("wait_busy", MemReq[32], 1);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      Req0 = '0; Req1 = '0; RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      RST = 1'b0; Req0 = '0; Req1 = '0;
      repeat (2) @(negedge CLK);
      chk("rst_memreq", MemReq, 0);
      chk("rst_rsp0", Rsp0, 0);
      chk("rst_rsp1", Rsp1, 0);
      chk("rst_grant", Grant, 0);
      RST = 1'b1;

      // Single read from client 0.
      drive_req(0, 32'h40, 1'b0, 1'b1);
      wait_rdy(0, lat0);
      chk("lat0", lat0, 5);
      chk("rsp1_idle", Rsp1[0], 0);
      chk("mreq_release", MemReq[32], 0);
      @(posedge CLK); #1;
      chk("mreq_idle", MemReq[32], 0);
      chk("rsp0_held", Rsp0[0], 1);

      // Simultaneous requests right after reset.
      do_reset();
      fork
         drive_req(0, 32'h100, 1'b0, 1'b1);
         drive_req(1, 32'h200, 1'b0, 1'b1);
      join
      wait_rdy(0, lat0);
      chk("rsp1_wait", Rsp1[0], 0);
      n = 0;
      do begin
         @(posedge CLK); #1; n++;
      end while (n < 20 && !MemReq[32]);
      chk("gap", n, 2);
      chk("grant1", Grant, 1);
      wait_rdy(1, lat1);

      // Back-to-back traffic from both clients.
      glog.delete();
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               drive_req(0, 32'h300 + 32'(i * 16), 1'b0, 1'b1);
               wait_rdy(0, lat0);
            end
         end
         begin
            for (int i = 0; i < 3; i++) begin
               drive_req(1, 32'h400 + 32'(i * 16), 1'b0, 1'b1);
               wait_rdy(1, lat1);
            end
         end
      join
      chk("g_cnt", glog.size(), 6);
      for (int i = 0; i < glog.size() && i < 6; i++) chk("g_seq", glog[i], i % 2);

      // Writeback, then a read on the same client without dropping valid.
      drive_req(1, 32'h80, 1'b1, 1'b1);
      wait_rdy(1, lat1);
      n = glog.size();
      drive_req(1, 32'h90, 1'b0, 1'b1);
      wait_rdy(1, lat1);
      chk("wb_regrant", glog.size(), n + 1);

      // Abort: client 0 drops valid while BUSY.
      drive_req(0, 32'hA0, 1'b0, 1'b0);
      wait_busy(1'b0);
      @(negedge CLK);
      Req0 = '0;
      @(posedge CLK); #1;
      chk("abort_mreq", MemReq[32], 0);
      for (int i = 0; i < 5; i++) begin
         chk("abort_rdy0", Rsp0[0], 0);
         @(posedge CLK); #1;
      end
      drive_req(0, 32'hB0, 1'b0, 1'b1);
      wait_rdy(0, lat0);

      // Reset while BUSY, then re-grant the pending request.
      @(negedge CLK);
      Req1 = '0;
      drive_req(0, 32'hC0, 1'b0, 1'b1);
      wait_busy(1'b0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("rstb_memreq", MemReq, 0);
      chk("rstb_rsp0", Rsp0, 0);
      chk("rstb_rsp1", Rsp1, 0);
      chk("rstb_grant", Grant, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      wait_rdy(0, lat0);

      repeat (3) @(posedge CLK);
      #1;
      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
